// File: rtl/avalon_crypto_csr.sv
// rtl/avalon_crypto_csr.sv - Avalon-MM register file and start/capture sequencer for a crypto core
// Key/message words feed the core directly; results are captured into RES on core done.
module avalon_crypto_csr #(
  parameter int DATA_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int MSG_WORDS = 4,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          AVL_READ,
  input  logic                          AVL_WRITE,
  input  logic                          AVL_CS,
  input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]             AVL_ADDR,
  input  logic [DATA_W-1:0]             AVL_WRITEDATA,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic                          AVL_IRQ,
  output logic                          CORE_START,
  input  logic                          CORE_DONE,
  output logic [KEY_WORDS*DATA_W-1:0]   CORE_KEY,
  output logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG_IN,
  input  logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG_OUT,
  output logic [DATA_W-1:0]             EXPORT_DATA
);

  localparam int NB        = DATA_W / 8;
  localparam int MSG_BASE  = KEY_WORDS;
  localparam int RES_BASE  = KEY_WORDS + MSG_WORDS;
  localparam int CTRL_ADDR = 2**ADDR_W - 2;
  localparam int STAT_ADDR = 2**ADDR_W - 1;
  localparam int CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_CAPTURE} state_t;

  state_t              state, next_state;
  logic [DATA_W-1:0]   key_r [KEY_WORDS];
  logic [DATA_W-1:0]   msg_r [MSG_WORDS];
  logic [DATA_W-1:0]   res_r [MSG_WORDS];
  logic [DATA_W-1:0]   rd_mux;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         addr;
  logic irq_en, done, err, tmo_flag;
  logic wr_en, rd_en, busy, is_key, is_msg, ctrl_wr, stat_wr, start_req, start_go;
  logic cap, tmo_hit, start_pulse, err_set;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [NB-1:0]     be);
    merge_bytes = old_v;
    for (int b = 0; b < NB; b++)
      if (be[b]) merge_bytes[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  assign addr      = 32'(AVL_ADDR);
  assign wr_en     = AVL_CS && AVL_WRITE;
  assign rd_en     = AVL_CS && AVL_READ;
  assign busy      = (state != S_IDLE);
  assign is_key    = (addr < 32'(MSG_BASE));
  assign is_msg    = (addr >= 32'(MSG_BASE)) && (addr < 32'(RES_BASE));
  assign ctrl_wr   = wr_en && (addr == 32'(CTRL_ADDR)) && AVL_BYTE_EN[0];
  assign stat_wr   = wr_en && (addr == 32'(STAT_ADDR)) && AVL_BYTE_EN[0];
  assign start_req = ctrl_wr && AVL_WRITEDATA[0];
  assign start_go  = start_req && !busy;
  // Host writes that would disturb an in-flight run are dropped and flagged.
  assign err_set   = tmo_hit || (busy && ((wr_en && (is_key || is_msg)) || start_req));
  assign CORE_START = start_pulse;

  always_comb begin
    next_state  = state;
    start_pulse = 1'b0;
    cap         = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      S_IDLE:    if (start_go) next_state = S_PULSE;
      S_PULSE: begin
        start_pulse = 1'b1;
        next_state  = S_WAIT;
      end
      S_WAIT: begin
        if (CORE_DONE) next_state = S_CAPTURE;
        else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_CAPTURE: begin
        cap        = 1'b1;
        next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == S_PULSE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < KEY_WORDS; i++) if (addr == 32'(i)) rd_mux = key_r[i];
    for (int i = 0; i < MSG_WORDS; i++) if (addr == 32'(MSG_BASE + i)) rd_mux = msg_r[i];
    for (int i = 0; i < MSG_WORDS; i++) if (addr == 32'(RES_BASE + i)) rd_mux = res_r[i];
    if (addr == 32'(CTRL_ADDR)) rd_mux[1]   = irq_en;
    if (addr == 32'(STAT_ADDR)) rd_mux[3:0] = {tmo_flag, err, busy, done};
  end

  always_comb begin
    CORE_KEY    = '0;
    CORE_MSG_IN = '0;
    for (int i = 0; i < KEY_WORDS; i++) CORE_KEY[(KEY_WORDS-1-i)*DATA_W +: DATA_W] = key_r[i];
    for (int i = 0; i < MSG_WORDS; i++) CORE_MSG_IN[(MSG_WORDS-1-i)*DATA_W +: DATA_W] = msg_r[i];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < KEY_WORDS; i++) key_r[i] <= '0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        msg_r[i] <= '0;
        res_r[i] <= '0;
      end
      irq_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tmo_flag     <= 1'b0;
      AVL_READDATA <= '0;
      AVL_IRQ      <= 1'b0;
      EXPORT_DATA  <= '0;
    end else begin
      for (int i = 0; i < KEY_WORDS; i++)
        if (wr_en && !busy && addr == 32'(i))
          key_r[i] <= merge_bytes(key_r[i], AVL_WRITEDATA, AVL_BYTE_EN);
      for (int i = 0; i < MSG_WORDS; i++) begin
        if (wr_en && !busy && addr == 32'(MSG_BASE + i))
          msg_r[i] <= merge_bytes(msg_r[i], AVL_WRITEDATA, AVL_BYTE_EN);
        if (cap) res_r[i] <= CORE_MSG_OUT[(MSG_WORDS-1-i)*DATA_W +: DATA_W];
      end
      if (ctrl_wr) irq_en <= AVL_WRITEDATA[1];
      // Capture outranks a same-edge host clear so a fresh result is never lost.
      if (cap)                              done <= 1'b1;
      else if (start_go)                    done <= 1'b0;
      else if (stat_wr && AVL_WRITEDATA[0]) done <= 1'b0;
      if (err_set)                          err <= 1'b1;
      else if (stat_wr && AVL_WRITEDATA[2]) err <= 1'b0;
      if (tmo_hit)                          tmo_flag <= 1'b1;
      else if (start_go)                    tmo_flag <= 1'b0;
      else if (stat_wr && AVL_WRITEDATA[3]) tmo_flag <= 1'b0;
      AVL_READDATA <= rd_en ? rd_mux : '0;
      AVL_IRQ      <= irq_en && (done || err);
      EXPORT_DATA  <= {res_r[0][DATA_W-1 -: DATA_W/2], res_r[MSG_WORDS-1][DATA_W/2-1:0]};
    end
  end

endmodule

// File: tb/tb_avalon_crypto_csr.sv
// tb/tb_avalon_crypto_csr.sv - scoreboard bench for avalon_crypto_csr
// Instance a uses the default watchdog, instance b a 16-cycle watchdog.
module tb_avalon_crypto_csr;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         avl_read = 1'b0, avl_write = 1'b0, avl_cs = 1'b0, sel = 1'b0;
  logic [3:0]   avl_be = 4'h0, avl_addr = 4'h0;
  logic [31:0]  avl_wdata = '0;
  logic [31:0]  rdata_a, rdata_b, export_a, export_b;
  logic         irq_a, irq_b, start_a, start_b;
  logic         core_done = 1'b0, core_auto = 1'b0, core_manual = 1'b0;
  logic [127:0] key_a, key_b, msgin_a, msgin_b;
  logic [127:0] msg_out = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic         cs_a, cs_b, rvalid = 1'b0;
  int           checks = 0, errors = 0, start_cnt = 0, core_cnt = 0;
  logic [31:0]  exp_q [$];
  string        tag_q [$];
  logic         dut_q [$];

  assign cs_a = avl_cs && !sel;
  assign cs_b = avl_cs && sel;

  always #5 clk = ~clk;

  avalon_crypto_csr u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .AVL_READ(avl_read), .AVL_WRITE(avl_write), .AVL_CS(cs_a),
    .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wdata), .AVL_READDATA(rdata_a),
    .AVL_IRQ(irq_a), .CORE_START(start_a), .CORE_DONE(core_done), .CORE_KEY(key_a),
    .CORE_MSG_IN(msgin_a), .CORE_MSG_OUT(msg_out), .EXPORT_DATA(export_a));

  avalon_crypto_csr #(.TIMEOUT(16)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .AVL_READ(avl_read), .AVL_WRITE(avl_write), .AVL_CS(cs_b),
    .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wdata), .AVL_READDATA(rdata_b),
    .AVL_IRQ(irq_b), .CORE_START(start_b), .CORE_DONE(core_done), .CORE_KEY(key_b),
    .CORE_MSG_IN(msgin_b), .CORE_MSG_OUT(msg_out), .EXPORT_DATA(export_b));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic avl_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = a; avl_wdata = d; avl_be = be;
    @(negedge clk);
    avl_cs = 1'b0; avl_write = 1'b0; avl_be = 4'h0;
  endtask

  task automatic avl_rd(input string tag, input logic [3:0] a, input logic [31:0] e);
    exp_q.push_back(e); tag_q.push_back(tag); dut_q.push_back(sel);
    avl_cs = 1'b1; avl_read = 1'b1; avl_addr = a;
    @(negedge clk);
    avl_cs = 1'b0; avl_read = 1'b0;
  endtask

  always @(posedge clk) rvalid <= avl_cs && avl_read;

  // Scoreboard: pop the expected word when registered read data appears.
  initial forever begin
    @(negedge clk);
    if (rvalid) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 1, 0);
      else check_eq(tag_q.pop_front(), dut_q.pop_front() ? rdata_b : rdata_a, exp_q.pop_front());
    end
  end

  // Core model for instance a: done one cycle, 20 cycles after start.
  initial forever begin
    @(negedge clk);
    if (start_a) start_cnt++;
    if (start_a && core_auto) core_cnt = 20;
    else if (core_cnt > 0) core_cnt--;
    core_done = core_auto ? (core_cnt == 1) : core_manual;
  end

  initial begin
    logic [31:0] k [4];
    logic [31:0] m [4];
    k = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
    m = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_irq", irq_a, 0);
    check_eq("rst_start", start_a, 0);
    check_eq("rst_export", export_a, 0);

    for (int a = 0; a < 16; a++) avl_rd($sformatf("t1_rd%0d", a), a[3:0], 32'h0);

    avl_wr(4'd0, 32'hFFFFFFFF, 4'hF);
    avl_wr(4'd0, 32'h12345678, 4'b0101);
    avl_rd("t2_merge", 4'd0, 32'hFF34FF78);
    @(negedge clk);
    check_eq("t2_rdata_idle", rdata_a, 0);

    core_auto = 1'b1;
    for (int i = 0; i < 4; i++) avl_wr(4'(i), k[i], 4'hF);
    for (int i = 0; i < 4; i++) avl_wr(4'(4 + i), m[i], 4'hF);
    check_eq("t3_core_key", key_a, {k[0], k[1], k[2], k[3]});
    check_eq("t3_core_msg", msgin_a, {m[0], m[1], m[2], m[3]});
    avl_wr(4'd14, 32'h3, 4'h1);
    for (int i = 0; i < 100 && !irq_a; i++) @(negedge clk);
    check_eq("t3_irq_wait", irq_a, 1);
    check_eq("t3_start_cnt", start_cnt, 1);
    check_eq("t3_export", export_a, 32'h0011EEFF);
    avl_rd("t3_status", 4'd15, 32'h1);
    avl_rd("t3_res0", 4'd8, 32'h00112233);
    avl_rd("t3_res1", 4'd9, 32'h44556677);
    avl_rd("t3_res2", 4'd10, 32'h8899AABB);
    avl_rd("t3_res3", 4'd11, 32'hCCDDEEFF);
    avl_rd("t3_ctrl", 4'd14, 32'h2);
    avl_wr(4'd15, 32'h1, 4'h1);
    @(negedge clk);
    check_eq("t3_irq_clr", irq_a, 0);
    avl_rd("t3_status_clr", 4'd15, 32'h0);

    avl_wr(4'd14, 32'h3, 4'h1);
    avl_wr(4'd4, 32'hDEADBEEF, 4'hF);
    avl_wr(4'd14, 32'h1, 4'h1);
    avl_rd("t4_status_busy", 4'd15, 32'h6);
    avl_rd("t4_msg0", 4'd4, m[0]);
    repeat (40) @(negedge clk);
    check_eq("t4_start_cnt", start_cnt, 2);
    check_eq("t4_irq_off", irq_a, 0);
    avl_rd("t4_status_end", 4'd15, 32'h5);
    avl_rd("t4_ctrl", 4'd14, 32'h0);
    avl_wr(4'd15, 32'hF, 4'h1);
    avl_rd("t4_status_clr", 4'd15, 32'h0);

    core_auto = 1'b0;
    sel = 1'b1;
    avl_wr(4'd14, 32'h1, 4'h1);
    repeat (15) @(negedge clk);
    avl_rd("t5_wait15", 4'd15, 32'h2);
    avl_rd("t5_wait16", 4'd15, 32'h2);
    avl_rd("t5_timeout", 4'd15, 32'hC);
    avl_rd("t5_res0", 4'd8, 32'h0);
    sel = 1'b0;

    avl_wr(4'd14, 32'h1, 4'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_manual = 1'b1;
    repeat (2) @(negedge clk);
    core_manual = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_start_cnt", start_cnt, 3);
    check_eq("t6_irq", irq_a, 0);
    check_eq("t6_export", export_a, 0);
    avl_rd("t6_status", 4'd15, 32'h0);
    for (int i = 0; i < 4; i++) avl_rd($sformatf("t6_res%0d", i), 4'(8 + i), 32'h0);
    avl_rd("t6_key0", 4'd0, 32'h0);

    repeat (2) @(negedge clk);
    check_eq("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
